// File: rtl/spi_fsm_pkg.sv
// spi_fsm_pkg: state encodings and default frame parameters shared by the SPI protocol controller
package spi_fsm_pkg;
  localparam int WORD_BITS_DEF = 8;
  localparam int CNT_W_DEF = 4;
  localparam int MEM_LATENCY_DEF = 1;
  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    GET_ADDR     = 4'd1,
    ADDR_LATCH   = 4'd2,
    READ_WAIT    = 4'd3,
    READ_LOAD    = 4'd4,
    READ_SHIFT   = 4'd5,
    WRITE_GET    = 4'd6,
    WRITE_COMMIT = 4'd7,
    DONE         = 4'd8
  } state_t;
endpackage

// File: rtl/spi_fsm_if.sv
// spi_fsm_if: controller <-> datapath signals of the SPI memory slave
//   cs_cond, sclk_pos, rw_bit : conditioned inputs into the controller
//   addr_we, dm_we, sr_we     : one-cycle datapath strobes
//   miso_buff, busy, state_dbg: MISO drive enable, activity flag, state for LEDs
//   rw                        : transfer direction latched at the address byte
interface spi_fsm_if;
  logic       cs_cond;
  logic       sclk_pos;
  logic       rw_bit;
  logic       addr_we;
  logic       dm_we;
  logic       sr_we;
  logic       miso_buff;
  logic       busy;
  logic [3:0] state_dbg;
  logic       rw;
  modport master (
    input  cs_cond, sclk_pos, rw_bit,
    output addr_we, dm_we, sr_we, miso_buff, busy, state_dbg, rw
  );
  modport slave (
    output cs_cond, sclk_pos, rw_bit,
    input  addr_we, dm_we, sr_we, miso_buff, busy, state_dbg, rw
  );
endinterface

// File: rtl/spi_fsm_bit_counter.sv
// spi_bit_counter: bit/latency counter with synchronous clear (priority) and count enable
//   clk, reset_n : clock, asynchronous active-low reset
//   clr, en      : clear to zero, increment by one
//   count        : current count
module spi_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
endmodule

// File: rtl/spi_fsm.sv
// spi_fsm: SPI memory protocol controller sequencing address latch, memory access and MISO drive
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : cs_cond/sclk_pos/rw_bit in; addr_we/dm_we/sr_we/miso_buff/busy/state_dbg/rw out
module spi_fsm
  import spi_fsm_pkg::*;
#(
  parameter int WORD_BITS   = WORD_BITS_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  spi_fsm_if.master   bus
);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_LAT = CNT_W'(MEM_LATENCY - 1);
  state_t           state, next;
  logic [CNT_W-1:0] cnt;
  logic             clr, en, rw_q, last_bit;
  spi_bit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .count(cnt)
  );
  assign last_bit = bus.sclk_pos && cnt == LAST_BIT;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      rw_q  <= 1'b0;
    end else begin
      state <= next;
      if (state == ADDR_LATCH) rw_q <= bus.rw_bit;
    end
  // CS high aborts from every state; the state-decoded strobe of the current cycle still fires.
  always_comb begin
    next = state;
    clr  = 1'b0;
    en   = 1'b0;
    if (bus.cs_cond && state != IDLE) begin
      next = IDLE;
      clr  = 1'b1;
    end else
      case (state)
        IDLE: begin
          next = bus.cs_cond ? IDLE : GET_ADDR;
          clr  = 1'b1;
        end
        GET_ADDR: begin
          en   = bus.sclk_pos;
          next = last_bit ? ADDR_LATCH : GET_ADDR;
        end
        ADDR_LATCH: begin
          clr  = 1'b1;
          next = bus.rw_bit ? READ_WAIT : WRITE_GET;
        end
        READ_WAIT: begin
          en   = 1'b1;
          next = cnt == LAST_LAT ? READ_LOAD : READ_WAIT;
        end
        READ_LOAD: begin
          clr  = 1'b1;
          next = READ_SHIFT;
        end
        READ_SHIFT: begin
          en   = bus.sclk_pos;
          next = last_bit ? DONE : READ_SHIFT;
        end
        WRITE_GET: begin
          en   = bus.sclk_pos;
          next = last_bit ? WRITE_COMMIT : WRITE_GET;
        end
        WRITE_COMMIT: next = DONE;
        DONE:         next = DONE;
        default:      next = IDLE;
      endcase
  end
  assign bus.addr_we   = state == ADDR_LATCH;
  assign bus.dm_we     = state == WRITE_COMMIT;
  assign bus.sr_we     = state == READ_LOAD;
  assign bus.miso_buff = state == READ_SHIFT;
  assign bus.busy      = state != IDLE;
  assign bus.state_dbg = state;
  assign bus.rw        = rw_q;
endmodule

// File: tb/tb_spi_fsm.sv
// tb_spi_fsm: directed self-checking bench for the SPI protocol controller
module tb_spi_fsm;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  int n_addr = 0, n_dm = 0, n_sr = 0, n_miso_pulse = 0, n_miso_cyc = 0, n_multi = 0;
  logic [8:0] obs;
  spi_fsm_if bus ();
  spi_fsm #(.WORD_BITS(8), .CNT_W(4), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  always #5 clk = ~clk;
  assign obs = {bus.state_dbg, bus.busy, bus.addr_we, bus.dm_we, bus.sr_we, bus.miso_buff};
  // Strobe activity tallied on the falling edge, away from the state update.
  always @(negedge clk) begin
    n_addr += int'(bus.addr_we);
    n_dm   += int'(bus.dm_we);
    n_sr   += int'(bus.sr_we);
    n_miso_cyc += int'(bus.miso_buff);
    if (bus.miso_buff && bus.sclk_pos) n_miso_pulse++;
    if (int'(bus.addr_we) + int'(bus.dm_we) + int'(bus.sr_we) > 1) n_multi++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse();
    bus.sclk_pos = 1'b1;
    tick();
    bus.sclk_pos = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    bus.cs_cond = 1'b0;
    bus.rw_bit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.sclk_pos = ~bus.sclk_pos;
      tick();
    end
    bus.sclk_pos = 1'b0;
    compared++;
    if (obs !== 9'h000 || bus.rw !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_hold: got %h/%b expected 000/0", obs, bus.rw);
    end
    bus.cs_cond = 1'b1;
    bus.rw_bit = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    compared++;
    if (obs !== 9'h000) begin
      mismatched++;
      $display("FAIL idle_cs_high: got %h expected 000", obs);
    end
    bus.cs_cond = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) pulse();
    bus.rw_bit = 1'b1;
    bus.sclk_pos = 1'b1;
    tick();
    bus.sclk_pos = 1'b0;
    compared++;
    if (obs !== {4'd2, 1'b1, 4'b1000}) begin
      mismatched++;
      $display("FAIL pre_async_latch: got %h expected %h", obs, {4'd2, 1'b1, 4'b1000});
    end
    reset_n = 1'b0;
    #1;
    compared++;
    if (obs !== 9'h000) begin
      mismatched++;
      $display("FAIL async_reset: got %h expected 000", obs);
    end
    bus.rw_bit = 1'b0;
    bus.cs_cond = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
  endtask
  task automatic do_read_frame(input string tag, input bit ign);
    int a0 = n_addr, d0 = n_dm, s0 = n_sr, m0 = n_miso_pulse;
    bus.cs_cond = 1'b0;
    tick();
    compared++;
    if (obs !== {4'd1, 1'b1, 4'b0000}) begin
      mismatched++;
      $display("FAIL %s_get_addr: got %h expected %h", tag, obs, {4'd1, 1'b1, 4'b0000});
    end
    for (int i = 0; i < 7; i++) pulse();
    bus.rw_bit = 1'b1;
    bus.sclk_pos = 1'b1;
    tick();
    bus.sclk_pos = ign;
    compared++;
    if (obs !== {4'd2, 1'b1, 4'b1000}) begin
      mismatched++;
      $display("FAIL %s_addr_latch: got %h expected %h", tag, obs, {4'd2, 1'b1, 4'b1000});
    end
    tick();
    bus.rw_bit = 1'b0;
    compared++;
    if (obs !== {4'd3, 1'b1, 4'b0000}) begin
      mismatched++;
      $display("FAIL %s_read_wait: got %h expected %h", tag, obs, {4'd3, 1'b1, 4'b0000});
    end
    tick();
    compared++;
    if (obs !== {4'd4, 1'b1, 4'b0010}) begin
      mismatched++;
      $display("FAIL %s_read_load: got %h expected %h", tag, obs, {4'd4, 1'b1, 4'b0010});
    end
    tick();
    bus.sclk_pos = 1'b0;
    compared++;
    if (obs !== {4'd5, 1'b1, 4'b0001} || bus.rw !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_read_shift: got %h/%b expected %h/1", tag, obs, bus.rw, {4'd5, 1'b1, 4'b0001});
    end
    for (int i = 0; i < 7; i++) pulse();
    compared++;
    if (obs !== {4'd5, 1'b1, 4'b0001}) begin
      mismatched++;
      $display("FAIL %s_shift_7: got %h expected %h", tag, obs, {4'd5, 1'b1, 4'b0001});
    end
    bus.sclk_pos = 1'b1;
    tick();
    bus.sclk_pos = 1'b0;
    compared++;
    if (obs !== {4'd8, 1'b1, 4'b0000}) begin
      mismatched++;
      $display("FAIL %s_done: got %h expected %h", tag, obs, {4'd8, 1'b1, 4'b0000});
    end
    compared++;
    if ({n_addr - a0, n_sr - s0, n_dm - d0, n_miso_pulse - m0} !== {32'd1, 32'd1, 32'd0, 32'd8}) begin
      mismatched++;
      $display("FAIL %s_counts: got addr=%0d sr=%0d dm=%0d miso=%0d expected 1 1 0 8",
               tag, n_addr - a0, n_sr - s0, n_dm - d0, n_miso_pulse - m0);
    end
  endtask
  task automatic test_read();
    do_read_frame("read", 1'b0);
    bus.cs_cond = 1'b1;
    tick();
    compared++;
    if (obs !== 9'h000) begin
      mismatched++;
      $display("FAIL read_cs_release: got %h expected 000", obs);
    end
  endtask
  task automatic test_write();
    int s0 = n_sr, d0 = n_dm, m0 = n_miso_cyc;
    logic [7:0] addr_byte = 8'h2A;
    bus.cs_cond = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) pulse();
    bus.rw_bit = addr_byte[0];
    bus.sclk_pos = 1'b1;
    tick();
    bus.sclk_pos = 1'b0;
    compared++;
    if (obs !== {4'd2, 1'b1, 4'b1000}) begin
      mismatched++;
      $display("FAIL write_addr_latch: got %h expected %h", obs, {4'd2, 1'b1, 4'b1000});
    end
    tick();
    compared++;
    if (obs !== {4'd6, 1'b1, 4'b0000} || bus.rw !== 1'b0) begin
      mismatched++;
      $display("FAIL write_get: got %h/%b expected %h/0", obs, bus.rw, {4'd6, 1'b1, 4'b0000});
    end
    for (int i = 0; i < 7; i++) pulse();
    compared++;
    if (obs !== {4'd6, 1'b1, 4'b0000}) begin
      mismatched++;
      $display("FAIL write_get_7: got %h expected %h", obs, {4'd6, 1'b1, 4'b0000});
    end
    bus.sclk_pos = 1'b1;
    tick();
    bus.sclk_pos = 1'b0;
    compared++;
    if (obs !== {4'd7, 1'b1, 4'b0100}) begin
      mismatched++;
      $display("FAIL write_commit: got %h expected %h", obs, {4'd7, 1'b1, 4'b0100});
    end
    tick();
    compared++;
    if (obs !== {4'd8, 1'b1, 4'b0000}) begin
      mismatched++;
      $display("FAIL write_done: got %h expected %h", obs, {4'd8, 1'b1, 4'b0000});
    end
    compared++;
    if ({n_dm - d0, n_sr - s0, n_miso_cyc - m0} !== {32'd1, 32'd0, 32'd0}) begin
      mismatched++;
      $display("FAIL write_counts: got dm=%0d sr=%0d miso=%0d expected 1 0 0",
               n_dm - d0, n_sr - s0, n_miso_cyc - m0);
    end
    bus.cs_cond = 1'b1;
    tick();
  endtask
  task automatic test_abort();
    int d0 = n_dm;
    bus.cs_cond = 1'b0;
    tick();
    bus.rw_bit = 1'b0;
    for (int i = 0; i < 12; i++) pulse();
    compared++;
    if (obs !== {4'd6, 1'b1, 4'b0000}) begin
      mismatched++;
      $display("FAIL abort_pre: got %h expected %h", obs, {4'd6, 1'b1, 4'b0000});
    end
    bus.cs_cond = 1'b1;
    tick();
    compared++;
    if (obs !== 9'h000) begin
      mismatched++;
      $display("FAIL abort_idle: got %h expected 000", obs);
    end
    tick();
    tick();
    compared++;
    if (n_dm - d0 !== 0) begin
      mismatched++;
      $display("FAIL abort_dm_we: got %0d expected 0", n_dm - d0);
    end
  endtask
  task automatic test_back_to_back();
    do_read_frame("b2b_first", 1'b0);
    for (int i = 0; i < 3; i++) pulse();
    compared++;
    if (obs !== {4'd8, 1'b1, 4'b0000}) begin
      mismatched++;
      $display("FAIL b2b_done_hold: got %h expected %h", obs, {4'd8, 1'b1, 4'b0000});
    end
    bus.cs_cond = 1'b1;
    tick();
    tick();
    do_read_frame("b2b_second", 1'b0);
    bus.cs_cond = 1'b1;
    tick();
  endtask
  task automatic test_ignored();
    do_read_frame("ignored", 1'b1);
    bus.cs_cond = 1'b1;
    tick();
  endtask
  task automatic test_exclusive();
    compared++;
    if (n_multi !== 0) begin
      mismatched++;
      $display("FAIL strobe_exclusive: got %0d overlapping cycles expected 0", n_multi);
    end
  endtask
  initial begin
    bus.cs_cond = 1'b1;
    bus.sclk_pos = 1'b0;
    bus.rw_bit = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_abort();
    test_back_to_back();
    test_ignored();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
